// File: rtl/led_demux4_ctrl_if.sv
// Switch-event and LED-drive bundle for led_demux4_ctrl.
// The master side drives the debounced levels; the slave side drives the LEDs.
interface led_demux4_ctrl_if;
   logic       i_Sel_Next;
   logic       i_Data_Toggle;
   logic       i_Clear;
   logic       i_Mode;
   logic [1:0] o_Sel;
   logic       o_LED_1;
   logic       o_LED_2;
   logic       o_LED_3;
   logic       o_LED_4;

   modport master (
      output i_Sel_Next,
      output i_Data_Toggle,
      output i_Clear,
      output i_Mode,
      input  o_Sel,
      input  o_LED_1,
      input  o_LED_2,
      input  o_LED_3,
      input  o_LED_4
   );

   modport slave (
      input  i_Sel_Next,
      input  i_Data_Toggle,
      input  i_Clear,
      input  i_Mode,
      output o_Sel,
      output o_LED_1,
      output o_LED_2,
      output o_LED_3,
      output o_LED_4
   );
endinterface

// File: rtl/led_demux4_ctrl.sv
// Registered 1-to-4 LED demultiplexer with a selection cursor,
// four latched LED bits and an optional blinking cursor indication.
module led_demux4_ctrl #(
   parameter int unsigned CLKS_PER_BLINK = 12500000
) (
   input logic             i_Clk,
   input logic             i_Rst_L,
   led_demux4_ctrl_if.slave bus
);

   localparam int CNT_W =
      (CLKS_PER_BLINK > 1) ? $clog2(CLKS_PER_BLINK) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX =
      CNT_W'(CLKS_PER_BLINK - 1);

   typedef enum logic {
      STATIC = 1'b0,
      BLINK  = 1'b1
   } state_t;

   state_t           r_State;
   state_t           state_d;

   logic [3:0]       r_Prev;
   logic [3:0]       in_now;
   logic [3:0]       rise;
   logic             sel_rise;
   logic             tog_rise;
   logic             clr_rise;
   logic             mode_rise;

   logic [1:0]       r_Sel;
   logic [3:0]       r_Latch;
   logic [3:0]       latch_d;
   logic [CNT_W-1:0] r_Cnt;
   logic             r_Phase;

   logic [3:0]       led_d;
   logic [3:0]       r_Led;
   logic [1:0]       r_Out_Sel;

   assign in_now = {bus.i_Mode, bus.i_Clear,
                    bus.i_Data_Toggle, bus.i_Sel_Next};
   assign rise      = in_now & ~r_Prev;
   assign sel_rise  = rise[0];
   assign tog_rise  = rise[1];
   assign clr_rise  = rise[2];
   assign mode_rise = rise[3];

   // Prev regs reset high so a level held through reset is not an event
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_Prev <= 4'hF;
      end else begin
         r_Prev <= in_now;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_Sel <= 2'd0;
      end else if (sel_rise) begin
         r_Sel <= r_Sel + 2'd1;
      end
   end

   // Clear wins over toggle; toggle uses the cursor before it advances
   always_comb begin
      latch_d = r_Latch;
      if (clr_rise) begin
         latch_d = 4'h0;
      end else if (tog_rise) begin
         latch_d[r_Sel] = ~r_Latch[r_Sel];
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_Latch <= 4'h0;
      end else begin
         r_Latch <= latch_d;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_Cnt   <= '0;
         r_Phase <= 1'b0;
      end else if (mode_rise) begin
         r_Cnt   <= '0;
         r_Phase <= 1'b0;
      end else if (r_Cnt == CNT_MAX) begin
         r_Cnt   <= '0;
         r_Phase <= ~r_Phase;
      end else begin
         r_Cnt   <= r_Cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_State <= STATIC;
      end else begin
         r_State <= state_d;
      end
   end

   always_comb begin
      state_d = r_State;
      unique case (r_State)
         STATIC: if (bus.i_Mode) state_d = BLINK;
         BLINK:  if (!bus.i_Mode) state_d = STATIC;
      endcase
   end

   always_comb begin
      led_d = r_Latch;
      unique case (r_State)
         STATIC: led_d = r_Latch;
         BLINK:  led_d[r_Sel] = r_Latch[r_Sel] ^ r_Phase;
      endcase
   end

   // Output stage samples the already-updated state: one extra edge
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_Led     <= 4'h0;
         r_Out_Sel <= 2'd0;
      end else begin
         r_Led     <= led_d;
         r_Out_Sel <= r_Sel;
      end
   end

   assign bus.o_Sel   = r_Out_Sel;
   assign bus.o_LED_1 = r_Led[0];
   assign bus.o_LED_2 = r_Led[1];
   assign bus.o_LED_3 = r_Led[2];
   assign bus.o_LED_4 = r_Led[3];

endmodule
